// File: rtl/vga_bar_pkg.sv
// rtl/vga_bar_pkg.sv - shared timing defaults, colour type and line/frame length helper
package vga_bar_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int total_len(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_bar_renderer_if.sv
// rtl/vga_bar_renderer_if.sv - register write port, pixel enable and VGA output bundle
interface vga_bar_renderer_if #(
    parameter int N_BARS = 15,
    parameter int BAR_W  = 8
) ();
    localparam int AW = (N_BARS > 1) ? $clog2(N_BARS) : 1;

    logic             pix_en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [BAR_W-1:0] wr_data;
    logic [7:0]       vga_r;
    logic [7:0]       vga_g;
    logic [7:0]       vga_b;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_blank_n;
    logic             vga_sync_n;
    logic             frame_start;

    modport master (
        output pix_en, wr_en, wr_addr, wr_data,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );

    modport slave (
        input  pix_en, wr_en, wr_addr, wr_data,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA h/v counters with sync, active-area and wrap strobes
module vga_timing_gen import vga_bar_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int HW       = $clog2(total_len(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(total_len(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          line_wrap,
    output logic          frame_wrap
);
    localparam int H_TOTAL  = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Decode on 32-bit copies so sync windows ending exactly at the total still compare
    always_comb begin
        line_wrap  = pix_en && (32'(h) == H_TOTAL - 1);
        frame_wrap = line_wrap && (32'(v) == V_TOTAL - 1);
        active     = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hs         = (32'(h) >= HS_START && 32'(h) < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs         = (32'(v) >= VS_START && 32'(v) < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (line_wrap) begin
                h <= '0;
                v <= frame_wrap ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_bar_renderer.sv
// rtl/vga_bar_renderer.sv - double-buffered horizontal bar graph renderer; PEAK_HOLD_EN adds decaying peak markers
module vga_bar_renderer import vga_bar_pkg::*; #(
    parameter int          N_BARS      = 15,
    parameter int          BAR_W       = 8,
    parameter int          SCALE_SHIFT = 1,
    parameter int          H_ACTIVE    = DEF_H_ACTIVE,
    parameter int          H_FP        = DEF_H_FP,
    parameter int          H_SYNC      = DEF_H_SYNC,
    parameter int          H_BP        = DEF_H_BP,
    parameter int          V_ACTIVE    = DEF_V_ACTIVE,
    parameter int          V_FP        = DEF_V_FP,
    parameter int          V_SYNC      = DEF_V_SYNC,
    parameter int          V_BP        = DEF_V_BP,
    parameter bit          SYNC_POL    = 1'b0,
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    vga_bar_renderer_if.slave  bus
);
    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = (N_BARS > 1) ? $clog2(N_BARS) : 1;
    localparam int BW      = $clog2(N_BARS + 1);
    localparam int BAND_H  = V_ACTIVE / N_BARS;
    localparam int RW      = (BAND_H > 1) ? $clog2(BAND_H) : 1;
    localparam int CW      = (BAR_W + SCALE_SHIFT > HW) ? BAR_W + SCALE_SHIFT : HW;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active, hs, vs, line_wrap, frame_wrap, swap;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL), .HW (HW), .VW (VW)
    ) u_timing (
        .clk        (CLOCK_50),
        .rst        (reset),
        .pix_en     (bus.pix_en),
        .h          (h),
        .v          (v),
        .active     (active),
        .hs         (hs),
        .vs         (vs),
        .line_wrap  (line_wrap),
        .frame_wrap (frame_wrap)
    );

    // Swap on the step that enters the first blanking line, so a whole frame sees one bank
    assign swap = line_wrap && (32'(v) == V_ACTIVE - 1);

    logic [BAR_W-1:0] shadow [N_BARS];
    logic [BAR_W-1:0] live   [N_BARS];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BARS; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            if (bus.wr_en && (32'(bus.wr_addr) < N_BARS))
                shadow[bus.wr_addr] <= bus.wr_data;
            if (swap) begin
                for (int i = 0; i < N_BARS; i++)
                    live[i] <= shadow[i];
            end
        end
    end

    // Band index runs one past the last bar and saturates there for the leftover lines
    logic [RW-1:0] band_row;
    logic [BW-1:0] band;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            band_row <= '0;
            band     <= '0;
        end else if (line_wrap) begin
            if (frame_wrap) begin
                band_row <= '0;
                band     <= '0;
            end else if (32'(band_row) == BAND_H - 1) begin
                band_row <= '0;
                if (32'(band) != N_BARS)
                    band <= band + 1'b1;
            end else begin
                band_row <= band_row + 1'b1;
            end
        end
    end

    logic             band_valid;
    logic [BAR_W-1:0] bar_val;
    logic [CW-1:0]    h_ext;
    logic [CW-1:0]    bar_len;

    always_comb begin
        band_valid = (32'(band) < N_BARS);
        bar_val    = band_valid ? live[AW'(band)] : '0;
        h_ext      = CW'(h);
        bar_len    = CW'(bar_val) << SCALE_SHIFT;
    end

    logic s1_active, s1_fg, s1_hs, s1_vs;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_fg     <= 1'b0;
            s1_hs     <= ~SYNC_POL;
            s1_vs     <= ~SYNC_POL;
        end else if (bus.pix_en) begin
            s1_active <= active;
            s1_fg     <= band_valid && (h_ext < bar_len);
            s1_hs     <= hs;
            s1_vs     <= vs;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int PEAK_DECAY = 4;
    localparam int DW         = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;

    logic [BAR_W-1:0] peak [N_BARS];
    logic [DW-1:0]    decay_cnt;
    logic             decay_hit;
    logic             s1_mark;
    logic [BAR_W-1:0] peak_val;
    logic [CW:0]      pk_lo;

    function automatic logic [BAR_W-1:0] peak_next(input logic [BAR_W-1:0] fresh,
                                                   input logic [BAR_W-1:0] held,
                                                   input logic             dec);
        logic [BAR_W-1:0] aged;
        aged = (dec && held != '0) ? held - 1'b1 : held;
        return (fresh > aged) ? fresh : aged;
    endfunction

    always_comb begin
        decay_hit = (32'(decay_cnt) == PEAK_DECAY - 1);
        peak_val  = band_valid ? peak[AW'(band)] : '0;
        pk_lo     = (CW + 1)'(CW'(peak_val) << SCALE_SHIFT);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            decay_cnt <= '0;
            for (int i = 0; i < N_BARS; i++)
                peak[i] <= '0;
        end else if (swap) begin
            decay_cnt <= decay_hit ? '0 : decay_cnt + 1'b1;
            for (int i = 0; i < N_BARS; i++)
                peak[i] <= peak_next(shadow[i], peak[i], decay_hit);
        end
    end

    // A zero peak draws no marker; otherwise every idle bar would carry a red stub at h=0
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            s1_mark <= 1'b0;
        else if (bus.pix_en)
            s1_mark <= band_valid && (peak_val != '0) &&
                       ({1'b0, h_ext} >= pk_lo) && ({1'b0, h_ext} < pk_lo + (CW + 1)'(2));
    end
`endif

    rgb_t px;
    rgb_t rgb;
    logic blank_n, hs_q, vs_q, fs_q;

    always_comb begin
        px = rgb_t'(24'h000000);
        if (s1_active) begin
            px = s1_fg ? rgb_t'(FG_RGB) : rgb_t'(BG_RGB);
`ifdef PEAK_HOLD_EN
            if (s1_mark)
                px = rgb_t'(24'hFF0000);
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rgb     <= rgb_t'(24'h000000);
            blank_n <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else if (bus.pix_en) begin
            rgb     <= px;
            blank_n <= s1_active;
            hs_q    <= s1_hs;
            vs_q    <= s1_vs;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            fs_q <= 1'b0;
        else
            fs_q <= swap;
    end

    assign bus.vga_r       = rgb.r;
    assign bus.vga_g       = rgb.g;
    assign bus.vga_b       = rgb.b;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n;
    assign bus.vga_sync_n  = 1'b1;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_bar_renderer.sv
// tb/tb_vga_bar_renderer.sv - randomized bench for vga_bar_renderer against a frame-position model
module tb_vga_bar_renderer;
    localparam int HA = 40, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 31, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FR = HT * VT;
    localparam int NB = 15;
    localparam int BAND = VA / NB;
    localparam int SWAP_POS = VA * HT;
    localparam int NPINS = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_bar_renderer_if #(.N_BARS(NB), .BAR_W(8)) bus ();

    vga_bar_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad = 0;
    int cnt;
    int last_fs;
    bit fs_m;
    logic [7:0] sh_m [NB];
    logic [7:0] lv_m [NB];

    bit pin_en = 0;
    int pin_hits = 0;
    int pin_q [NPINS] = '{43, 44, 51, 52, 1847, 1848, 1959, 1960, 5, 40, 61, 1736,
                          2147, 2148, 2464, 2503, 2504, 2504, 3696};
    int pin_f [NPINS] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 0, 3,
                          0, 0, 0, 0, 0, 3, 0};
    int pin_v [NPINS] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0,
                          24'hFFFFFF, 0, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cnt=%0d: got=%0h expected=%0h", name, cnt, got, exp);
        end
    endtask

    task automatic model_reset();
        cnt = 0;
        fs_m = 0;
        last_fs = -1;
        for (int i = 0; i < NB; i++) begin
            sh_m[i] = 8'd0;
            lv_m[i] = 8'd0;
        end
    endtask

    function automatic void expect_px(input int q, output logic [23:0] rgb, output bit bl,
                                      output bit hs, output bit vs);
        int hq, vq, band;
        hq = q % HT;
        vq = (q / HT) % VT;
        band = vq / BAND;
        bl = (hq < HA) && (vq < VA);
        hs = !(hq >= HA + HFP && hq < HA + HFP + HSW);
        vs = !(vq >= VA + VFP && vq < VA + VFP + VSW);
        rgb = 24'h000000;
        if (bl && band < NB && hq < int'(lv_m[band]) * 2)
            rgb = 24'hFFFFFF;
    endfunction

    task automatic check();
        logic [23:0] e_rgb, d_rgb;
        bit e_bl, e_hs, e_vs;
        int q;
        q = cnt - 2;
        d_rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
        if (cnt < 2) begin
            e_rgb = 24'h0; e_bl = 0; e_hs = 1; e_vs = 1;
        end else begin
            expect_px(q, e_rgb, e_bl, e_hs, e_vs);
        end
        chk("rgb", d_rgb, e_rgb);
        chk("blank_n", bus.vga_blank_n, e_bl);
        chk("hs", bus.vga_hs, e_hs);
        chk("vs", bus.vga_vs, e_vs);
        chk("sync_n", bus.vga_sync_n, 1);
        chk("frame_start", bus.frame_start, fs_m);
        if (bus.frame_start === 1'b1) begin
            if (last_fs >= 0)
                chk("frame_len", cnt - last_fs, FR);
            last_fs = cnt;
        end
        if (pin_en && cnt >= 2) begin
            for (int k = 0; k < NPINS; k++) begin
                if (pin_q[k] == q) begin
                    pin_hits++;
                    case (pin_f[k])
                        0: chk("pin_rgb", d_rgb, pin_v[k]);
                        1: chk("pin_hs", bus.vga_hs, pin_v[k]);
                        2: chk("pin_vs", bus.vga_vs, pin_v[k]);
                        default: chk("pin_blank_n", bus.vga_blank_n, pin_v[k]);
                    endcase
                end
            end
        end
    endtask

    task automatic step(input bit pe, input bit we, input int addr, input int data);
        bus.pix_en  = pe;
        bus.wr_en   = we;
        bus.wr_addr = addr[3:0];
        bus.wr_data = data[7:0];
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            fs_m = 0;
            if (pe && ((cnt + 1) % FR) == SWAP_POS) begin
                lv_m = sh_m;
                fs_m = 1;
            end
            if (we && addr < NB)
                sh_m[addr] = data[7:0];
            if (pe)
                cnt++;
        end
        #1;
        check();
    endtask

    task automatic run_until(input int target, input string name);
        int guard;
        guard = 0;
        while (cnt < target && guard < 3 * FR) begin
            step(1, 0, 0, 0);
            guard++;
        end
        chk(name, (cnt == target), 1);
    endtask

    initial begin
        int base, a, d;
        bit we;
        rst = 1'b1;
        bus.pix_en = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        model_reset();
        repeat (3) step(1, 1, 2, 9);
        #2 rst = 1'b0;

        // Directed frame pair from reset: timing pins, deferred bar updates, clipping, ignored address
        pin_en = 1;
        for (int i = 0; i < 2 * FR + 60; i++) begin
            we = 1; a = 0; d = 0;
            case (cnt)
                50:  begin a = 0;  d = 10;  end
                200: begin a = 3;  d = 255; end
                201: begin a = 14; d = 0;   end
                202: begin a = 15; d = 77;  end
                default: we = 0;
            endcase
            step(1, we, a, d);
        end
        pin_en = 0;
        chk("pins_hit", pin_hits, NPINS);

        // Write landing on the swap edge: old value this frame, new value next frame
        base = 0;
        while (((cnt + 1) % FR) != SWAP_POS && base < 2 * FR) begin
            step(1, 0, 0, 0);
            base++;
        end
        step(1, 1, 0, 20);
        base = cnt - SWAP_POS + FR;
        run_until(base + 20 + 2, "reach_old_frame");
        chk("coinc_old", {bus.vga_r, bus.vga_g, bus.vga_b}, 24'h000000);
        run_until(base + FR + 20 + 2, "reach_new_frame");
        chk("coinc_new", {bus.vga_r, bus.vga_g, bus.vga_b}, 24'hFFFFFF);

        for (int i = 0; i < 20000; i++) begin
            if (i == 9000) begin
                rst = 1'b1;
                step(1, 1, 1, 5);
                step(0, 0, 0, 0);
                #2 rst = 1'b0;
            end
            we = ($urandom_range(0, 15) == 0);
            a = $urandom_range(0, 15);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 24);
            step($urandom_range(0, 3) != 0, we, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
